track_controller: RTL and testbench

TRACK_CONTROLLER -- requirements
Module: track_controller

---
 rtl/track_controller.sv | 178 +++++++++++++++++
 tb/tb_track_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/track_controller.sv
// Line-following robot controller: debounced 3-sensor decode, obstacle stop,
// SEARCH timeout to HALT. Ports: clk, reset(async low), detect_road, start,
// obstacle -> motor_mode, left_speed, right_speed, busy, lost.
module track_controller #(
  parameter int unsigned STABLE_CYC   = 4,
  parameter int unsigned LOST_TIMEOUT = 1000000,
  parameter logic [9:0]  FAST_SPD     = 10'd700,
  parameter logic [9:0]  SLOW_SPD     = 10'd400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] detect_road,
  input  logic       start,
  input  logic       obstacle,
  output logic [1:0] motor_mode,
  output logic [9:0] left_speed,
  output logic [9:0] right_speed,
  output logic       busy,
  output logic       lost
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FOLLOW,
    S_TURN_L,
    S_TURN_R,
    S_SEARCH,
    S_BLOCKED,
    S_HALT
  } state_e;

  localparam logic [1:0]  M_STOP = 2'd0;
  localparam logic [1:0]  M_FWD  = 2'd1;
  localparam logic [1:0]  M_TL   = 2'd2;
  localparam logic [1:0]  M_TR   = 2'd3;

  localparam logic [3:0]  RUN_MAX = 4'hF;
  localparam logic [3:0]  RUN_HIT = 4'(STABLE_CYC - 1);
  localparam logic [23:0] LOST_LAST = 24'(LOST_TIMEOUT - 1);

  state_e      state;
  state_e      state_nx;
  logic [2:0]  sample;
  logic [2:0]  filt;
  logic [3:0]  run;
  logic [3:0]  run_nx;
  logic [23:0] lost_cnt;
  logic        dir_r;
  logic        dir_nx;
  logic        lost_nx;
  logic        same;

  // dir_r: 0 = last turn was left, 1 = right
  assign same = (detect_road == sample);

  always_comb begin
    run_nx = '0;
    if (same)
      run_nx = (run == RUN_MAX) ? run : run + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample <= 3'b010;
      filt   <= 3'b010;
      run    <= '0;
    end else begin
      sample <= detect_road;
      run    <= run_nx;
      if (same && run_nx >= RUN_HIT)
        filt <= detect_road;
    end
  end

  always_comb begin
    state_nx = state;
    dir_nx   = dir_r;
    lost_nx  = lost;
    case (state)
      S_IDLE: begin
        if (start)
          state_nx = obstacle ? S_BLOCKED : S_FOLLOW;
      end
      S_HALT: begin
        if (start) begin
          state_nx = obstacle ? S_BLOCKED : S_FOLLOW;
          lost_nx  = 1'b0;
        end
      end
      S_BLOCKED: begin
        if (!obstacle)
          state_nx = S_FOLLOW;
      end
      default: begin
        if (obstacle) begin
          state_nx = S_BLOCKED;
        end else begin
          unique case (filt)
            3'b010, 3'b111: state_nx = S_FOLLOW;
            3'b100, 3'b110: begin
              state_nx = S_TURN_L;
              dir_nx   = 1'b0;
            end
            3'b001, 3'b011: begin
              state_nx = S_TURN_R;
              dir_nx   = 1'b1;
            end
            3'b101: state_nx = state;
            3'b000: begin
              if (state == S_SEARCH &&
                  lost_cnt == LOST_LAST) begin
                state_nx = S_HALT;
                lost_nx  = 1'b1;
              end else begin
                state_nx = S_SEARCH;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      dir_r    <= 1'b0;
      lost     <= 1'b0;
      lost_cnt <= '0;
    end else begin
      state <= state_nx;
      dir_r <= dir_nx;
      lost  <= lost_nx;
      if (state != S_SEARCH)
        lost_cnt <= '0;
      else if (filt == 3'b000 &&
               lost_cnt != LOST_LAST)
        lost_cnt <= lost_cnt + 24'd1;
    end
  end

  always_comb begin
    motor_mode  = M_STOP;
    left_speed  = '0;
    right_speed = '0;
    busy        = 1'b1;
    unique case (state)
      S_FOLLOW: begin
        motor_mode  = M_FWD;
        left_speed  = FAST_SPD;
        right_speed = FAST_SPD;
      end
      S_TURN_L: begin
        motor_mode  = M_TL;
        left_speed  = SLOW_SPD;
        right_speed = FAST_SPD;
      end
      S_TURN_R: begin
        motor_mode  = M_TR;
        left_speed  = FAST_SPD;
        right_speed = SLOW_SPD;
      end
      S_SEARCH: begin
        // pivot toward the side the line was last seen on
        if (dir_r) begin
          motor_mode = M_TR;
          left_speed = SLOW_SPD;
        end else begin
          motor_mode  = M_TL;
          right_speed = SLOW_SPD;
        end
      end
      S_BLOCKED: ;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_track_controller.sv
// Scoreboard bench for track_controller: driver pushes reference-model
// expectations, monitor pops and compares every cycle.
module tb_track_controller;

  localparam int         SC   = 4;
  localparam int         LT   = 8;
  localparam logic [9:0] FAST = 10'd700;
  localparam logic [9:0] SLOW = 10'd400;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] detect_road;
  logic       start;
  logic       obstacle;
  logic [1:0] motor_mode;
  logic [9:0] left_speed;
  logic [9:0] right_speed;
  logic       busy;
  logic       lost;

  track_controller #(
    .STABLE_CYC  (SC),
    .LOST_TIMEOUT(LT),
    .FAST_SPD    (FAST),
    .SLOW_SPD    (SLOW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .detect_road(detect_road),
    .start      (start),
    .obstacle   (obstacle),
    .motor_mode (motor_mode),
    .left_speed (left_speed),
    .right_speed(right_speed),
    .busy       (busy),
    .lost       (lost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic [9:0] ls;
    logic [9:0] rs;
    logic       busy;
    logic       lost;
  } exp_t;

  typedef enum int {
    R_IDLE, R_FOLLOW, R_TL, R_TR, R_SEARCH, R_BLOCKED, R_HALT
  } rst_e;

  exp_t       expq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 0;

  rst_e       ms;
  bit         m_right;
  bit         m_lost;
  int         m_dwell;
  logic [2:0] mf;
  logic [2:0] hist[$];

  function automatic exp_t model_out();
    exp_t e;
    e = '{mode: 2'd0, ls: 10'd0, rs: 10'd0, busy: 1'b1, lost: m_lost};
    case (ms)
      R_FOLLOW: begin e.mode = 2'd1; e.ls = FAST; e.rs = FAST; end
      R_TL:     begin e.mode = 2'd2; e.ls = SLOW; e.rs = FAST; end
      R_TR:     begin e.mode = 2'd3; e.ls = FAST; e.rs = SLOW; end
      R_SEARCH: begin
        if (m_right) begin e.mode = 2'd3; e.ls = SLOW; end
        else         begin e.mode = 2'd2; e.rs = SLOW; end
      end
      R_BLOCKED: ;
      default: e.busy = 1'b0;
    endcase
    return e;
  endfunction

  function automatic void model_reset();
    ms      = R_IDLE;
    m_right = 0;
    m_lost  = 0;
    m_dwell = 0;
    mf      = 3'b010;
    hist.delete();
    hist.push_back(3'b010);
  endfunction

  function automatic void model_step(logic [2:0] raw, bit st, bit ob);
    rst_e nx;
    bit   all_eq;
    nx = ms;
    if (ms == R_IDLE || ms == R_HALT) begin
      if (st) begin
        nx = ob ? R_BLOCKED : R_FOLLOW;
        m_lost = 0;
      end
    end else if (ob) begin
      nx = R_BLOCKED;
    end else if (ms == R_BLOCKED) begin
      nx = R_FOLLOW;
    end else if (mf == 3'b010 || mf == 3'b111) begin
      nx = R_FOLLOW;
    end else if (mf == 3'b100 || mf == 3'b110) begin
      nx = R_TL; m_right = 0;
    end else if (mf == 3'b001 || mf == 3'b011) begin
      nx = R_TR; m_right = 1;
    end else if (mf == 3'b000) begin
      // give up after LT cycles of line-less searching
      if (ms == R_SEARCH && m_dwell == LT - 1) begin
        nx = R_HALT; m_lost = 1;
      end else begin
        nx = R_SEARCH;
      end
    end
    if (ms != R_SEARCH) m_dwell = 0;
    else if (mf == 3'b000) m_dwell++;
    ms = nx;
    // accept a pattern once the last SC samples are identical
    hist.push_back(raw);
    if (hist.size() > SC) void'(hist.pop_front());
    all_eq = (hist.size() == SC);
    foreach (hist[i]) if (hist[i] != raw) all_eq = 0;
    if (all_eq) mf = raw;
  endfunction

  task automatic chk(input string name, input exp_t e);
    exp_t g;
    g = {motor_mode, left_speed, right_speed, busy, lost};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t: got mode=%0d l=%0d r=%0d busy=%0b lost=%0b, want mode=%0d l=%0d r=%0d busy=%0b lost=%0b",
               name, $time, g.mode, g.ls, g.rs, g.busy, g.lost,
               e.mode, e.ls, e.rs, e.busy, e.lost);
    end
  endtask

  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL underflow t=%0t: got no expectation, want one", $time);
      end else begin
        chk("cycle", expq.pop_front());
      end
    end
  end

  // called at a negedge; returns at the next negedge
  task automatic cyc(input logic [2:0] raw, input bit st,
                     input bit ob, input bit rs = 1'b1);
    detect_road = raw;
    start       = st;
    obstacle    = ob;
    reset       = rs;
    if (!rs) model_reset();
    else model_step(raw, st, ob);
    expq.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] raw, input bit st,
                     input bit ob, input int n);
    for (int i = 0; i < n; i++) cyc(raw, st, ob);
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    start = 1'b0;
    #1 model_reset();
    chk("async_reset", model_out());
    expq.push_back(model_out());
    @(negedge clk);
    cyc(3'b010, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] pats[8];
    logic [2:0] p;
    bit         ob;
    pats = '{3'b010, 3'b110, 3'b100, 3'b011,
             3'b001, 3'b000, 3'b101, 3'b111};
    reset = 1'b0;
    detect_road = 3'b010;
    start = 1'b0;
    obstacle = 1'b0;
    model_reset();
    #2 chk("reset_state", model_out());
    @(negedge clk);
    mon_en = 1;
    cyc(3'b010, 1'b0, 1'b0, 1'b0);
    // directed scenarios
    cyc(3'b010, 1'b1, 1'b0);
    run(3'b010, 1'b0, 1'b0, 4);
    run(3'b110, 1'b0, 1'b0, 3);
    run(3'b010, 1'b0, 1'b0, 5);
    run(3'b110, 1'b0, 1'b0, 6);
    run(3'b110, 1'b0, 1'b1, 2);
    run(3'b110, 1'b0, 1'b0, 3);
    run(3'b011, 1'b0, 1'b0, 6);
    run(3'b101, 1'b0, 1'b0, 6);
    run(3'b000, 1'b0, 1'b0, 16);
    cyc(3'b000, 1'b1, 1'b0);
    run(3'b000, 1'b0, 1'b0, 7);
    async_reset();
    run(3'b010, 1'b0, 1'b0, 4);
    cyc(3'b010, 1'b1, 1'b1);
    run(3'b010, 1'b0, 1'b1, 2);
    run(3'b010, 1'b0, 1'b0, 3);
    // randomized phase
    ob = 0;
    for (int seg = 0; seg < 500; seg++) begin
      p = pats[$urandom_range(0, 7)];
      if ($urandom_range(0, 14) == 0) ob = ~ob;
      for (int k = 0; k < int'($urandom_range(1, 8)); k++)
        cyc(p, ($urandom_range(0, 9) == 0), ob);
      if ($urandom_range(0, 60) == 0) async_reset();
    end
    run(3'b000, 1'b0, 1'b0, 20);
    cyc(3'b010, 1'b1, 1'b0);
    run(3'b010, 1'b0, 1'b0, 5);
    mon_en = 0;
    #3;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d queued, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
